fixed_add_sub_pipe: RTL and testbench

//  Pipelined signed fixed-point adder/subtractor with valid/ready handshake for the ODE solver datapath.

---
 rtl/fixed_add_sub_pipe.sv | 196 +++++++++++++++++++
 tb/tb_fixed_add_sub_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_add_sub_pipe.sv
// fixed_add_sub_pipe
// Pipelined signed fixed-point adder/subtractor with a valid/ready handshake.
// It also has an internal accumulator mode and a sticky overflow flag.
// It sits between the ODE solver step sequencer and the multiplier/state-update stages.
//
// Parameters
//   WIDTH   operand/result width, two's complement
//   FRAC    fractional bits (Q(WIDTH-FRAC).FRAC); add/sub needs no alignment,
//           so FRAC only takes part in the configuration sanity check
//   STAGES  pipeline register stages (1..4); latency when out_ready is held high
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   operand/op presented
//   in_ready    out  block can accept this cycle
//   op          in   00 A+B | 01 A-B | 10 ACC+A | 11 ACC-A
//   a, b        in   signed operands (b ignored for op 1x)
//   acc_clr     in   synchronous accumulator and sticky clear
//   out_valid   out  result available
//   out_ready   in   consumer takes result
//   result      out  signed result
//   overflow    out  overflow of this result, aligned with result
//   ovf_sticky  out  OR of all accepted overflows since rst or acc_clr
//
// Build option
//   SATURATE_EN  when defined, overflowing results clamp to the most positive or
//                most negative value, and the accumulator stores the clamped value.
//                When it is undefined, results and the accumulator wrap modulo 2^WIDTH.
//                overflow/ovf_sticky behave the same in both builds.

module fixed_add_sub_pipe #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             ovf_sticky
);

  // A parameter set outside the supported range never accepts work. This makes
  // a bad instantiation obvious in simulation instead of producing odd results.
  localparam bit CFG_OK = (FRAC >= 0) && (FRAC < WIDTH) && (STAGES >= 1) && (STAGES <= 4);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Pipeline stage registers; index STAGES-1 drives the outputs.
  logic             stg_valid_q [STAGES];
  logic             stg_valid_d [STAGES];
  logic [WIDTH-1:0] stg_res_q   [STAGES];
  logic [WIDTH-1:0] stg_res_d   [STAGES];
  logic             stg_ovf_q   [STAGES];
  logic             stg_ovf_d   [STAGES];

  // Accumulator and sticky overflow state.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_sticky_q;
  logic             ovf_sticky_d;

  // Stage-1 arithmetic.
  logic             advance;
  logic             accept;
  logic             acc_op;
  logic             sub_op;
  logic [WIDTH-1:0] x_opnd;
  logic [WIDTH-1:0] y_opnd;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   y_term;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] sum_res;

  // Global stall: when the output slot is full and not being taken, every
  // stage holds, including bubbles. Bubbles are not collapsed.
  always_comb begin
    advance = !stg_valid_q[STAGES-1] || out_ready;
    accept  = in_valid && advance && CFG_OK;
  end

  assign in_ready = advance && CFG_OK;

  // Operand selection and the sign-extended WIDTH+1 sum. Subtraction is done
  // as X + ~Y + 1 in the wide domain, so subtracting the most negative value
  // is still exact and its overflow is flagged. When acc_clr arrives together
  // with an accumulate op, a zero accumulator is used. This matches the
  // "clear first, then accumulate" behaviour.
  always_comb begin
    acc_op = op[1];
    sub_op = op[0];
    if (acc_op) begin
      x_opnd = acc_clr ? '0 : acc_q;
      y_opnd = a;
    end else begin
      x_opnd = a;
      y_opnd = b;
    end
    x_ext   = {x_opnd[WIDTH-1], x_opnd};
    y_term  = sub_op ? ~{y_opnd[WIDTH-1], y_opnd} : {y_opnd[WIDTH-1], y_opnd};
    sum     = x_ext + y_term + {{WIDTH{1'b0}}, sub_op};
    sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
`ifdef SATURATE_EN
    // The wide sum's top bit gives the true sign of the sum, so it selects the clamp direction.
    if (sum_ovf) begin
      sum_res = sum[WIDTH] ? MIN_NEG : MAX_POS;
    end else begin
      sum_res = sum[WIDTH-1:0];
    end
`else
    sum_res = sum[WIDTH-1:0];
`endif
  end

  // The accumulator takes the new value in the accept cycle, so the next
  // accumulate op can chain back-to-back with no hazard. acc_clr without an
  // accepted accumulate op clears both the accumulator and the sticky flag.
  // With an accepted accumulate op, sticky restarts from that op's overflow.
  always_comb begin
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;
    if (accept && acc_op) begin
      acc_d        = sum_res;
      ovf_sticky_d = acc_clr ? sum_ovf : (ovf_sticky_q | sum_ovf);
    end else if (acc_clr) begin
      acc_d        = '0;
      ovf_sticky_d = 1'b0;
    end else if (accept && sum_ovf) begin
      ovf_sticky_d = 1'b1;
    end
  end

  // Next-state for the pipeline: shift everything by one on advance, hold otherwise.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stg_valid_d[i] = stg_valid_q[i];
      stg_res_d[i]   = stg_res_q[i];
      stg_ovf_d[i]   = stg_ovf_q[i];
    end
    if (advance) begin
      stg_valid_d[0] = accept;
      stg_res_d[0]   = sum_res;
      stg_ovf_d[0]   = sum_ovf;
      for (int i = 1; i < STAGES; i++) begin
        stg_valid_d[i] = stg_valid_q[i-1];
        stg_res_d[i]   = stg_res_q[i-1];
        stg_ovf_d[i]   = stg_ovf_q[i-1];
      end
    end
  end

  // Pipeline state. Reset discards every in-flight op immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_valid_q[i] <= 1'b0;
        stg_res_q[i]   <= '0;
        stg_ovf_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stg_valid_q[i] <= stg_valid_d[i];
        stg_res_q[i]   <= stg_res_d[i];
        stg_ovf_q[i]   <= stg_ovf_d[i];
      end
    end
  end

  // Accumulator and sticky overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = stg_valid_q[STAGES-1];
  assign result     = stg_res_q[STAGES-1];
  assign overflow   = stg_ovf_q[STAGES-1];
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixed_add_sub_pipe.sv
// tb_fixed_add_sub_pipe
// Self-checking bench for fixed_add_sub_pipe (WIDTH=16, FRAC=8, STAGES=2).
// Inputs are driven on the falling edge and outputs are sampled 1 time unit later.
// The reference model uses plain integer arithmetic and keeps a queue of expected results.

module tb_fixed_add_sub_pipe;

  localparam int WIDTH  = 16;
  localparam int FRAC   = 8;
  localparam int STAGES = 2;

`ifdef SATURATE_EN
  localparam logic [15:0] EXP_OVF_POS  = 16'h7FFF;
  localparam logic [15:0] EXP_OVF_NEG  = 16'h8000;
  localparam logic [15:0] EXP_SUB_MIN  = 16'h7FFF;
`else
  localparam logic [15:0] EXP_OVF_POS  = 16'h80FF;
  localparam logic [15:0] EXP_OVF_NEG  = 16'h7980;
  localparam logic [15:0] EXP_SUB_MIN  = 16'h8000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        ovf_sticky;

  always #5 clk = ~clk;

  fixed_add_sub_pipe #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .STAGES(STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .ovf_sticky(ovf_sticky)
  );

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          acc_cycle;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [15:0] model_acc;
  logic        model_sticky;
  bit          lat_check;
  bit          prev_stall;
  logic [15:0] prev_res;
  logic        prev_ovf;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: exact integer sum, range test, optional clamp.
  function automatic void modelOp(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                                  input logic clr, output logic [15:0] r, output logic ov);
    int x;
    int y;
    int s;
    x  = o[1] ? (clr ? 0 : int'($signed(model_acc))) : int'($signed(av));
    y  = o[1] ? int'($signed(av)) : int'($signed(bv));
    s  = o[0] ? (x - y) : (x + y);
    ov = (s > 32767) || (s < -32768);
`ifdef SATURATE_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    r = s[15:0];
  endfunction

  // One clock cycle: drive inputs, check outputs/handshake, update the model, then advance.
  task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [15:0] av,
                               input logic [15:0] bv, input logic clr, input logic ordy,
                               input bit has_exp, input logic [15:0] exp_res, input logic exp_ovf,
                               output bit accepted);
    exp_t        e;
    logic [15:0] r;
    logic        ov;
    in_valid  = v;
    op        = o;
    a         = av;
    b         = bv;
    acc_clr   = clr;
    out_ready = ordy;
    #1;
    checkOutput("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, model_sticky});
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (out_valid !== 1'b1) || ordy});
    if (prev_stall) begin
      checkOutput("hold_result", {16'b0, result}, {16'b0, prev_res});
      checkOutput("hold_overflow", {31'b0, overflow}, {31'b0, prev_ovf});
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else if (ordy) begin
        e = exp_q.pop_front();
        checkOutput("result", {16'b0, result}, {16'b0, e.res});
        checkOutput("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        if (e.chk_lat) checkOutput("latency", cycle - e.acc_cycle, STAGES);
      end
    end
    prev_stall = (out_valid === 1'b1) && !ordy;
    prev_res   = result;
    prev_ovf   = overflow;
    accepted   = v && (in_ready === 1'b1);
    if (accepted) begin
      modelOp(o, av, bv, clr, r, ov);
      if (has_exp) begin
        r  = exp_res;
        ov = exp_ovf;
      end
      e.res = r;
      e.ovf = ov;
      e.acc_cycle = cycle;
      e.chk_lat = lat_check;
      exp_q.push_back(e);
      if (o[1]) begin
        model_acc    = r;
        model_sticky = clr ? ov : (model_sticky | ov);
      end else if (clr) begin
        model_acc    = 16'h0000;
        model_sticky = 1'b0;
      end else begin
        model_sticky = model_sticky | ov;
      end
    end else if (clr) begin
      model_acc    = 16'h0000;
      model_sticky = 1'b0;
    end
    @(negedge clk);
    cycle++;
  endtask

  // Present one op with out_ready high until it is accepted (bounded).
  task automatic sendOp(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic clr, input bit has_exp, input logic [15:0] er, input logic eo);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++) applyStimulus(1'b1, o, av, bv, clr, 1'b1, has_exp, er, eo, acc);
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic clr);
    bit acc;
    for (int t = 0; t < n; t++) applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, clr, 1'b1, 1'b0, 16'h0, 1'b0, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++)
      applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, acc);
    idle(3, 1'b0);
    checkOutput("drain_empty", exp_q.size(), 32'd0);
  endtask

  function automatic logic [15:0] pickVal();
    case ($urandom_range(0, 6))
      0:       pickVal = 16'h7FFF;
      1:       pickVal = 16'h8000;
      2:       pickVal = 16'h0000;
      3:       pickVal = 16'hFFFF;
      default: pickVal = 16'($urandom);
    endcase
  endfunction

  initial begin
    bit          acc;
    int          idx;
    logic [1:0]  rop;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; acc_clr = 1'b0; out_ready = 1'b1;
    model_acc = 16'h0000; model_sticky = 1'b0; prev_stall = 1'b0; prev_res = '0; prev_ovf = 1'b0;
    lat_check = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_result", {16'b0, result}, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("rst_ovf_sticky", {31'b0, ovf_sticky}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] test 1: add/sub without overflow");
    sendOp(2'b00, 16'h3330, 16'h0000, 1'b0, 1'b1, 16'h3330, 1'b0);
    sendOp(2'b00, 16'h0F30, 16'h0F30, 1'b0, 1'b1, 16'h1E60, 1'b0);
    sendOp(2'b00, 16'hFA80, 16'h0440, 1'b0, 1'b1, 16'hFEC0, 1'b0);
    sendOp(2'b01, 16'h0580, 16'h0440, 1'b0, 1'b1, 16'h0140, 1'b0);
    drain();

    $display("[TB] test 2: overflow");
    sendOp(2'b00, 16'h7FFF, 16'h0100, 1'b0, 1'b1, EXP_OVF_POS, 1'b1);
    sendOp(2'b00, 16'hF400, 16'h8580, 1'b0, 1'b1, EXP_OVF_NEG, 1'b1);
    drain();

    $display("[TB] test 3: accumulate chain");
    idle(1, 1'b1);
    sendOp(2'b10, 16'h0100, 16'hDEAD, 1'b0, 1'b1, 16'h0100, 1'b0);
    sendOp(2'b10, 16'h0100, 16'hBEEF, 1'b0, 1'b1, 16'h0200, 1'b0);
    sendOp(2'b10, 16'h0100, 16'h1234, 1'b0, 1'b1, 16'h0300, 1'b0);
    sendOp(2'b11, 16'h0400, 16'h0000, 1'b0, 1'b1, 16'hFF00, 1'b0);
    sendOp(2'b10, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h0200, 1'b0);
    drain();

    $display("[TB] test 6: subtract most negative value");
    sendOp(2'b01, 16'h0000, 16'h8000, 1'b0, 1'b1, EXP_SUB_MIN, 1'b1);
    drain();

    $display("[TB] test 4: backpressure");
    lat_check = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && !(idx == 6 && exp_q.size() == 0); c++) begin
      if (idx < 6)
        applyStimulus(1'b1, 2'b00, 16'(idx * 16'h0010 + 16'h0001), 16'h0100, 1'b0,
                      !(c >= 3 && c <= 7), 1'b0, 16'h0, 1'b0, acc);
      else
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, !(c >= 3 && c <= 7), 1'b0, 16'h0, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("bp_all_accepted", idx, 32'd6);
    drain();

    $display("[TB] test 5: reset mid-operation");
    sendOp(2'b10, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    sendOp(2'b00, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_ovf_sticky", {31'b0, ovf_sticky}, 32'd0);
    @(negedge clk);
    cycle++;
    rst = 1'b0;
    exp_q.delete();
    model_acc = 16'h0000;
    model_sticky = 1'b0;
    prev_stall = 1'b0;
    idle(4, 1'b0);
    lat_check = 1'b1;
    sendOp(2'b10, 16'h0123, 16'h0000, 1'b0, 1'b1, 16'h0123, 1'b0);
    drain();

    $display("[TB] randomized traffic");
    lat_check = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rop = 2'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 3) != 0), rop, pickVal(), pickVal(),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
                    1'b0, 16'h0, 1'b0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
